// File: rtl/fetch_splitter_pkg.sv
// rtl/fetch_splitter_pkg.sv - shared fetch/decode widths and slot helpers
package fetch_splitter_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam int PKT_W   = 2 * INSTR_W;

  // Bit 2 of a packet PC names the first slot worth decoding after a redirect.
  function automatic logic start_slot(input logic [XLEN-1:0] pc);
    return pc[2];
  endfunction

endpackage

// File: rtl/fetch_splitter.sv
// rtl/fetch_splitter.sv - splits two-slot fetch packets into one instruction per cycle
module fetch_splitter
  import fetch_splitter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [XLEN-1:0]    a_pc,
  input  logic [PKT_W-1:0]   a_instr,
  input  logic               a_fault,
  input  logic               a_valid,
  output logic               a_ready,
  output logic [XLEN-1:0]    b_pc,
  output logic [INSTR_W-1:0] b_instr,
  output logic               b_fault,
  output logic               b_valid,
  input  logic               b_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SLOT0 = 2'd1,
    ST_SLOT1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [XLEN-1:3]   pkt_pc_hi;
  logic [PKT_W-1:0]  pkt_instr;
  logic              pkt_fault;
  logic              fire;
  logic              last_fire;
  logic              accept;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^a_pc[1:0];

  always_comb begin
    b_valid   = (state != ST_EMPTY);
    fire      = b_valid && b_ready;
    // A faulted packet retires after its first emitted slot.
    last_fire = fire && ((state == ST_SLOT1) || pkt_fault);
    a_ready   = !flush && ((state == ST_EMPTY) || last_fire);
    accept    = a_valid && a_ready;

    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else if (accept) begin
      state_nxt = start_slot(a_pc) ? ST_SLOT1 : ST_SLOT0;
    end else if (fire) begin
      state_nxt = last_fire ? ST_EMPTY : ST_SLOT1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      pkt_pc_hi <= '0;
      pkt_instr <= '0;
      pkt_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pkt_pc_hi <= a_pc[XLEN-1:3];
        pkt_instr <= a_instr;
        pkt_fault <= a_fault;
      end
    end
  end

  always_comb begin
    b_instr = (state == ST_SLOT1) ? pkt_instr[PKT_W-1:INSTR_W] : pkt_instr[INSTR_W-1:0];
    b_pc    = {pkt_pc_hi, (state == ST_SLOT1), 2'b00};
    b_fault = pkt_fault;
  end

endmodule

// File: tb/tb_fetch_splitter.sv
// tb/tb_fetch_splitter.sv - table-driven scoreboard bench for fetch_splitter
module tb_fetch_splitter;
  import fetch_splitter_pkg::*;

  logic               clk = 1'b0;
  logic               rst, flush;
  logic [XLEN-1:0]    a_pc;
  logic [PKT_W-1:0]   a_instr;
  logic               a_fault, a_valid, a_ready;
  logic [XLEN-1:0]    b_pc;
  logic [INSTR_W-1:0] b_instr;
  logic               b_fault, b_valid, b_ready;

  fetch_splitter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_pc(a_pc), .a_instr(a_instr), .a_fault(a_fault), .a_valid(a_valid), .a_ready(a_ready),
    .b_pc(b_pc), .b_instr(b_instr), .b_fault(b_fault), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } exp_t;

  typedef struct {
    logic [XLEN-1:0]  pc;
    logic [PKT_W-1:0] instr;
    logic             fault;
    int               n_out;
    exp_t             e0;
    exp_t             e1;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   fire_cyc[$];
  vec_t vecs[9];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: sample just before each rising edge, pop on every accepted output.
  always @(negedge clk) begin
    #4;
    if (!rst && !flush && b_valid && b_ready) begin
      fire_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual pc=%h instr=%h required none", b_pc, b_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (b_pc !== mon_e.pc || b_instr !== mon_e.instr || b_fault !== mon_e.fault) begin
          failures++;
          $display("FAIL output actual pc=%h instr=%h fault=%b required pc=%h instr=%h fault=%b",
                   b_pc, b_instr, b_fault, mon_e.pc, mon_e.instr, mon_e.fault);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input vec_t v, input bit push);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    a_pc = v.pc; a_instr = v.instr; a_fault = v.fault; a_valid = 1'b1;
    while (!ok && n < 50) begin
      #4;
      if (a_ready) begin
        ok = 1;
        if (push) begin
          exp_q.push_back(v.e0);
          if (v.n_out == 2) exp_q.push_back(v.e1);
        end
      end
      @(negedge clk);
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted pc=%h", v.pc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic vec_t mk(input logic [63:0] pc, input logic [63:0] instr, input logic f,
                              input int n, input logic [63:0] p0, input logic [31:0] i0,
                              input logic [63:0] p1, input logic [31:0] i1);
    vec_t v;
    v.pc = pc; v.instr = instr; v.fault = f; v.n_out = n;
    v.e0.pc = p0; v.e0.instr = i0; v.e0.fault = f;
    v.e1.pc = p1; v.e1.instr = i1; v.e1.fault = f;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   total;
    vecs[0] = mk(64'h1000, 64'h11111111_00000013, 0, 2, 64'h1000, 32'h00000013, 64'h1004, 32'h11111111);
    vecs[1] = mk(64'h1008, 64'h22222222_33333333, 0, 2, 64'h1008, 32'h33333333, 64'h100C, 32'h22222222);
    vecs[2] = mk(64'h2004, 64'hAAAAAAAA_BBBBBBBB, 0, 1, 64'h2004, 32'hAAAAAAAA, 64'h0, 32'h0);
    vecs[3] = mk(64'h2008, 64'hCCCCCCCC_DDDDDDDD, 0, 2, 64'h2008, 32'hDDDDDDDD, 64'h200C, 32'hCCCCCCCC);
    vecs[4] = mk(64'h3000, 64'h44444444_55555555, 1, 1, 64'h3000, 32'h55555555, 64'h0, 32'h0);
    vecs[5] = mk(64'h3008, 64'h66666666_77777777, 0, 2, 64'h3008, 32'h77777777, 64'h300C, 32'h66666666);
    vecs[6] = mk(64'h300E, 64'h88888888_99999999, 1, 1, 64'h300C, 32'h88888888, 64'h0, 32'h0);
    vecs[7] = mk(64'hFFFFFFFF_FFFFFFF8, 64'h9ABCDEF0_12345678, 0, 2,
                 64'hFFFFFFFF_FFFFFFF8, 32'h12345678, 64'hFFFFFFFF_FFFFFFFC, 32'h9ABCDEF0);
    vecs[8] = mk(64'h7003, 64'hDEADBEEF_CAFEF00D, 0, 2, 64'h7000, 32'hCAFEF00D, 64'h7004, 32'hDEADBEEF);

    rst = 1'b1; flush = 1'b0; b_ready = 1'b1;
    a_pc = '0; a_instr = '0; a_fault = 1'b0; a_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_b_valid", 64'(b_valid), 64'd0);
    check("reset_b_pc", b_pc, 64'd0);
    check("reset_b_instr", 64'(b_instr), 64'd0);
    check("reset_b_fault", 64'(b_fault), 64'd0);
    check("reset_a_ready", 64'(a_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back stream: every output on consecutive cycles.
    fire_cyc.delete();
    total = 0;
    foreach (vecs[i]) begin
      send(vecs[i], 1'b1);
      total += vecs[i].n_out;
    end
    a_valid = 1'b0;
    drain();
    check("stream_output_count", 64'(fire_cyc.size()), 64'(total));
    if (fire_cyc.size() > 0)
      check("stream_no_bubbles", 64'(fire_cyc[fire_cyc.size()-1] - fire_cyc[0]), 64'(total - 1));

    // Backpressure in SLOT0.
    b_ready = 1'b0;
    send(vecs[0], 1'b1);
    a_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      check("bp_b_valid", 64'(b_valid), 64'd1);
      check("bp_b_pc", b_pc, 64'h1000);
      check("bp_b_instr", 64'(b_instr), 64'h00000013);
      check("bp_a_ready", 64'(a_ready), 64'd0);
      @(negedge clk);
    end
    b_ready = 1'b1;
    drain();

    // Flush while holding a packet in SLOT0, with a new packet offered.
    b_ready = 1'b0;
    v = mk(64'h5000, 64'h55555555_50505050, 0, 2, 64'h5000, 32'h50505050, 64'h5004, 32'h55555555);
    send(v, 1'b0);
    flush = 1'b1; b_ready = 1'b1;
    a_pc = 64'h6000; a_instr = 64'h66666666_60606060; a_fault = 1'b0; a_valid = 1'b1;
    #4;
    check("flush_a_ready", 64'(a_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; a_valid = 1'b0;
    #1;
    check("flush_b_valid_next", 64'(b_valid), 64'd0);
    @(negedge clk);
    v = mk(64'h4000, 64'h40404040_04040404, 0, 2, 64'h4000, 32'h04040404, 64'h4004, 32'h40404040);
    send(v, 1'b1);
    a_valid = 1'b0;
    drain();

    // Asynchronous reset between clock edges while a packet is held.
    b_ready = 1'b0;
    v = mk(64'h8000, 64'h80808080_08080808, 1, 1, 64'h8000, 32'h08080808, 64'h0, 32'h0);
    send(v, 1'b0);
    a_valid = 1'b0;
    #2;
    check("pre_reset_b_valid", 64'(b_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_b_valid", 64'(b_valid), 64'd0);
    check("async_rst_b_pc", b_pc, 64'd0);
    check("async_rst_b_instr", 64'(b_instr), 64'd0);
    check("async_rst_b_fault", 64'(b_fault), 64'd0);
    check("async_rst_a_ready", 64'(a_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0; b_ready = 1'b1;
    v = mk(64'h9004, 64'h90909090_09090909, 0, 1, 64'h9004, 32'h90909090, 64'h0, 32'h0);
    send(v, 1'b1);
    a_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_splitter.md
# fetch_splitter

Consumes 64-bit fetch packets (two 32-bit instruction slots plus packet PC) from the fetch-side two-entry buffer and emits one instruction per cycle to decode. It handles a misaligned entry PC after a redirect, forwards fetch access faults, and drops buffered state on pipeline flush. Valid/ready on both sides; full throughput is one instruction per cycle.

## Interface
- `XLEN`, 64, PC width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous pipeline flush, drops held packet
- `a_pc`  in  XLEN  packet PC; bits [1:0] ignored, bit [2] selects start slot
- `a_instr`  in  64  slot 0 in [31:0], slot 1 in [63:32]
- `a_fault`  in  1  fetch access fault for this packet
- `a_valid`  in  1  packet valid
- `a_ready`  out  1  packet accepted when `a_valid && a_ready`
- `b_pc`  out  XLEN  instruction PC
- `b_instr`  out  32  instruction word
- `b_fault`  out  1  instruction carries access fault
- `b_valid`  out  1  instruction valid
- `b_ready`  in  1  decode accepts when `b_valid && b_ready`

## Operation
- State: EMPTY, SLOT0 (emit low half next), SLOT1 (emit high half next). Holding registers `pkt_pc`, `pkt_instr`, `pkt_fault`.
- Outputs are combinational from holding registers: `b_valid` = state != EMPTY; `b_instr` = SLOT1 ? `pkt_instr[63:32]` : `pkt_instr[31:0]`; `b_pc` = {`pkt_pc[XLEN-1:3]`, SLOT1, 2'b00}; `b_fault` = `pkt_fault`.
- `a_ready` = !flush && (EMPTY || (SLOT1 && b_ready) || (SLOT0 && pkt_fault && b_ready)).
- Accept: load holding regs; next state SLOT1 if `a_pc[2]`, else SLOT0.
- Fire in SLOT0, no fault: -> SLOT1.
- Fire in SLOT0 with fault, or fire in SLOT1: -> accepted packet's start slot if simultaneous accept, else EMPTY. Faulted packet emits exactly one instruction.
- flush: next state EMPTY regardless of handshakes; `a_ready` low that cycle; `b_valid` may still be high in the flush cycle, and decode ignores it.
- `b_ready` without `b_valid`: no effect. `a_valid` while `a_ready` low: packet held upstream, not sampled.

## Timing
- Reset: state EMPTY, holding regs 0; `b_valid`=0, `b_pc`=0, `b_instr`=0, `b_fault`=0, `a_ready`=1 (if flush low).
- Latency: instruction visible on `b_*` the cycle after packet accept.
- Throughput: aligned packet 2 cycles, misaligned or faulted packet 1 cycle; back-to-back accept in the same cycle as last-slot fire gives no bubbles.
- `a_ready` depends combinationally on `b_ready` and `flush`; `b_*` do not depend on `a_*` combinationally.
- Reset asserted mid-packet: immediate EMPTY, held packet lost.

## Structure
- `XLEN` and instruction width are shared design-wide constants in the common definitions package. State encoding is local.
- Single module, no sub-modules. Upstream buffering is external.

## Test plan
- Aligned stream: packets pc 0x1000/0x1008, instrs 0x11111111_00000013, 0x22222222_33333333, `b_ready`=1 -> outputs (0x1000,0x00000013),(0x1004,0x11111111),(0x1008,0x33333333),(0x100C,0x22222222) on 4 consecutive cycles.
- Misaligned redirect: a_pc=0x2004, instr 0xAAAAAAAA_BBBBBBBB -> single output (0x2004,0xAAAAAAAA), next packet accepted same cycle.
- Fault: a_pc=0x3000, a_fault=1 -> one output pc 0x3000 with b_fault=1, no 0x3004 output.
- Backpressure: `b_ready`=0 for 3 cycles in SLOT0 -> b_pc/b_instr stable, a_ready=0; release -> sequence resumes unchanged.
- Flush in SLOT0 with a_valid=1 -> a_ready=0 that cycle, b_valid=0 next cycle, next packet 0x4000 emitted normally.
- Async reset pulse mid-packet -> b_valid drops without clock edge, all b_* 0, a_ready=1.
